// File: rtl/wb_alu_mul.sv
// Wishbone pipelined ALU slave: WIDTH-bit add/sub with carry chaining,
// logic ops, shifts, and a bus-stalling shift-add unsigned multiplier.
module wb_alu_mul #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 8
) (
   input  logic             i_clk,
   input  logic             reset_n,
   input  logic             i_wb_stb,
   input  logic             i_wb_we,
   input  logic [AW-1:0]    i_wb_addr,
   input  logic [WIDTH-1:0] i_wb_data,
   output logic             o_wb_ack,
   output logic             o_wb_stall,
   output logic [WIDTH-1:0] o_wb_data
);

   localparam int unsigned MSB = WIDTH - 1;
   localparam int unsigned PW  = 2 * WIDTH;
   localparam int unsigned CW  = $clog2(WIDTH);

   localparam logic [AW-1:0] ADDR_A     = AW'(8'h00);
   localparam logic [AW-1:0] ADDR_B     = AW'(8'h01);
   localparam logic [AW-1:0] ADDR_FLAGS = AW'(8'h02);
   localparam logic [AW-1:0] ADDR_R     = AW'(8'h03);
   localparam logic [AW-1:0] ADDR_RH    = AW'(8'h04);
   localparam logic [AW-1:0] OP_ADD     = AW'(8'h80);
   localparam logic [AW-1:0] OP_ADC     = AW'(8'h81);
   localparam logic [AW-1:0] OP_SUB     = AW'(8'h82);
   localparam logic [AW-1:0] OP_SBC     = AW'(8'h83);
   localparam logic [AW-1:0] OP_AND     = AW'(8'h84);
   localparam logic [AW-1:0] OP_OR      = AW'(8'h85);
   localparam logic [AW-1:0] OP_XOR     = AW'(8'h86);
   localparam logic [AW-1:0] OP_SHL     = AW'(8'h87);
   localparam logic [AW-1:0] OP_SHR     = AW'(8'h88);
   localparam logic [AW-1:0] OP_MUL     = AW'(8'h89);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [WIDTH-1:0] a, b, r, rh;
   logic             c, z, v, n;
   logic [PW-1:0]    mcand, acc;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             sub_op, cin, op_hit;
   logic [WIDTH-1:0] b_op, alu_res, read_data;
   logic [WIDTH:0]   sum_ext;
   logic             alu_c, alu_v;
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] flags_word;

   assign accept     = i_wb_stb && !o_wb_stall;
   assign o_wb_stall = (state == BUSY);
   assign flags_word = WIDTH'({n, v, 4'b0000, z, c});

   // Single-cycle ALU datapath and register read mux, decoded from the address
   always_comb begin
      sub_op    = 1'b0;
      cin       = 1'b0;
      op_hit    = 1'b1;
      alu_res   = '0;
      alu_c     = c;
      alu_v     = v;
      read_data = '0;
      case (i_wb_addr)
         OP_ADC:  cin = c;
         OP_SUB:  begin sub_op = 1'b1; cin = 1'b1; end
         OP_SBC:  begin sub_op = 1'b1; cin = c;    end
         default: ;
      endcase
      b_op    = sub_op ? ~b : b;
      sum_ext = {1'b0, a} + {1'b0, b_op} + (WIDTH+1)'(cin);
      case (i_wb_addr)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (a[MSB] == b_op[MSB]) && (sum_ext[MSB] != a[MSB]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SHL:  begin alu_res = {a[MSB-1:0], 1'b0}; alu_c = a[MSB]; end
         OP_SHR:  begin alu_res = {1'b0, a[MSB:1]};   alu_c = a[0];   end
         default: op_hit = 1'b0;
      endcase
      case (i_wb_addr)
         ADDR_A:     read_data = a;
         ADDR_B:     read_data = b;
         ADDR_FLAGS: read_data = flags_word;
         ADDR_R:     read_data = r;
         ADDR_RH:    read_data = rh;
         default:    read_data = '0;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      acc_next = acc + (mplier[0] ? mcand : '0);
   end

   // Bus handling, register file and multiply FSM
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         a         <= '0;
         b         <= '0;
         r         <= '0;
         rh        <= '0;
         c         <= 1'b0;
         z         <= 1'b0;
         v         <= 1'b0;
         n         <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  o_wb_ack <= 1'b1;
                  if (i_wb_we) begin
                     case (i_wb_addr)
                        ADDR_A:     a <= i_wb_data;
                        ADDR_B:     b <= i_wb_data;
                        ADDR_FLAGS: begin
                           c <= i_wb_data[0];
                           z <= i_wb_data[1];
                           v <= i_wb_data[6];
                           n <= i_wb_data[7];
                        end
                        default: ;
                     endcase
                  end else if (i_wb_addr == OP_MUL) begin
                     o_wb_ack <= 1'b0;
                     state    <= BUSY;
                     mcand    <= PW'(a);
                     mplier   <= b;
                     acc      <= '0;
                     cnt      <= '0;
                  end else if (op_hit) begin
                     r         <= alu_res;
                     o_wb_data <= alu_res;
                     c         <= alu_c;
                     v         <= alu_v;
                     z         <= (alu_res == '0);
                     n         <= alu_res[MSB];
                  end else begin
                     o_wb_data <= read_data;
                  end
               end
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= {mcand[PW-2:0], 1'b0};
               mplier <= {1'b0, mplier[MSB:1]};
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state     <= IDLE;
                  o_wb_ack  <= 1'b1;
                  o_wb_data <= acc_next[WIDTH-1:0];
                  r         <= acc_next[WIDTH-1:0];
                  rh        <= acc_next[PW-1:WIDTH];
                  z         <= (acc_next == '0);
                  n         <= acc_next[PW-1];
                  c         <= (acc_next[PW-1:WIDTH] != '0);
                  v         <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_alu_mul.sv
// Randomized self-checking bench for wb_alu_mul against an arithmetic reference model.
module tb_wb_alu_mul;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = 8;

   logic             i_clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             i_wb_stb = 1'b0;
   logic             i_wb_we = 1'b0;
   logic [AW-1:0]    i_wb_addr = '0;
   logic [WIDTH-1:0] i_wb_data = '0;
   logic             o_wb_ack;
   logic             o_wb_stall;
   logic [WIDTH-1:0] o_wb_data;

   int checks = 0;
   int errors = 0;

   // Reference model state
   longint ma, mb, mr, mrh;
   int     mc, mz, mv, mn;

   wb_alu_mul #(.WIDTH(WIDTH), .AW(AW)) dut (
      .i_clk      (i_clk),
      .reset_n    (reset_n),
      .i_wb_stb   (i_wb_stb),
      .i_wb_we    (i_wb_we),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data),
      .o_wb_ack   (o_wb_ack),
      .o_wb_stall (o_wb_stall),
      .o_wb_data  (o_wb_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      ma = 0; mb = 0; mr = 0; mrh = 0;
      mc = 0; mz = 0; mv = 0; mn = 0;
   endfunction

   function automatic void set_zn(input longint res);
      mz = (res == 0) ? 1 : 0;
      mn = int'((res >> (WIDTH - 1)) & 1);
   endfunction

   // Returns the ack data the spec requires and updates the model state
   function automatic logic [WIDTH-1:0] model_access(input logic we, input int addr, input longint d);
      longint mask = (64'sd1 <<< WIDTH) - 1;
      longint half = 64'sd1 <<< (WIDTH - 1);
      longint s, sa, sb, sr, res, p;
      if (we) begin
         case (addr)
            0: ma = d & mask;
            1: mb = d & mask;
            2: begin
               mc = int'(d & 1); mz = int'((d >> 1) & 1);
               mv = int'((d >> 6) & 1); mn = int'((d >> 7) & 1);
            end
            default: ;
         endcase
         return '0;
      end
      sa = (ma >= half) ? ma - 2 * half : ma;
      sb = (mb >= half) ? mb - 2 * half : mb;
      case (addr)
         0: return WIDTH'(ma);
         1: return WIDTH'(mb);
         2: return WIDTH'(mn * 128 + mv * 64 + mz * 2 + mc);
         3: return WIDTH'(mr);
         4: return WIDTH'(mrh);
         'h80, 'h81: begin
            s  = ma + mb + ((addr == 'h81) ? mc : 0);
            sr = sa + sb + ((addr == 'h81) ? mc : 0);
            res = s & mask;
            mc = (s > mask) ? 1 : 0;
            mv = (sr > half - 1 || sr < -half) ? 1 : 0;
         end
         'h82, 'h83: begin
            s  = ma - mb - ((addr == 'h83) ? 1 - mc : 0);
            sr = sa - sb - ((addr == 'h83) ? 1 - mc : 0);
            res = s & mask;
            mc = (s >= 0) ? 1 : 0;
            mv = (sr > half - 1 || sr < -half) ? 1 : 0;
         end
         'h84: res = ma & mb;
         'h85: res = ma | mb;
         'h86: res = ma ^ mb;
         'h87: begin mc = int'((ma >> (WIDTH - 1)) & 1); res = (ma * 2) & mask; end
         'h88: begin mc = int'(ma & 1); res = ma / 2; end
         'h89: begin
            p   = ma * mb;
            mr  = p & mask;
            mrh = p >> WIDTH;
            mz  = (p == 0) ? 1 : 0;
            mn  = int'((p >> (2 * WIDTH - 1)) & 1);
            mc  = (mrh != 0) ? 1 : 0;
            mv  = 0;
            return WIDTH'(mr);
         end
         default: return '0;
      endcase
      mr = res;
      set_zn(res);
      return WIDTH'(res);
   endfunction

   // One non-overlapped transaction; for MUL also checks the stall window and ack timing
   task automatic xact(input logic we, input int addr, input longint d, input string tag);
      logic [WIDTH-1:0] exp;
      exp = model_access(we, addr, d);
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = AW'(addr);
      i_wb_data = WIDTH'(d);
      @(posedge i_clk); #1;
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
      if (!we && addr == 'h89) begin
         for (int i = 1; i <= WIDTH; i++) begin
            check({tag, "_stall"}, 64'(o_wb_stall), 64'(1));
            check({tag, "_noack"}, 64'(o_wb_ack), 64'(0));
            @(posedge i_clk); #1;
         end
         check({tag, "_stall_drop"}, 64'(o_wb_stall), 64'(0));
      end
      check({tag, "_ack"}, 64'(o_wb_ack), 64'(1));
      check({tag, "_data"}, 64'(o_wb_data), 64'(exp));
   endtask

   function automatic longint rand_data();
      logic [WIDTH-1:0] edges [4];
      edges[0] = '0; edges[1] = '1;
      edges[2] = {1'b0, {(WIDTH-1){1'b1}}}; edges[3] = {1'b1, {(WIDTH-1){1'b0}}};
      if ($urandom_range(0, 2) == 0) return longint'(edges[$urandom_range(0, 3)]);
      return longint'(WIDTH'($urandom));
   endfunction

   initial begin
      int addrs [16];
      int pa [5];
      logic pw [5];
      longint pd [5];
      logic [WIDTH-1:0] pe [5];
      int sel;

      addrs = '{0, 1, 2, 3, 4, 'h80, 'h81, 'h82, 'h83, 'h84, 'h85, 'h86, 'h87, 'h88, 'h89, 'h10};
      model_reset();

      #12;
      check("rst_ack", 64'(o_wb_ack), 64'(0));
      check("rst_stall", 64'(o_wb_stall), 64'(0));
      check("rst_data", 64'(o_wb_data), 64'(0));
      @(posedge i_clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) xact(1'b0, i, 0, "rst_reg");

      // Directed plan
      xact(1'b1, 0, 'h7F, "w_a"); xact(1'b1, 1, 'h01, "w_b");
      xact(1'b0, 'h80, 0, "add_ovf"); xact(1'b0, 2, 0, "add_flags");
      xact(1'b1, 2, 'h01, "w_flags"); xact(1'b1, 0, 'hFF, "w_a"); xact(1'b1, 1, 'h00, "w_b");
      xact(1'b0, 'h81, 0, "adc_carry"); xact(1'b0, 2, 0, "adc_flags");
      xact(1'b1, 0, 'h05, "w_a"); xact(1'b1, 1, 'h05, "w_b");
      xact(1'b0, 'h82, 0, "sub_zero"); xact(1'b0, 2, 0, "sub_zero_flags");
      xact(1'b1, 0, 'h00, "w_a"); xact(1'b1, 1, 'h01, "w_b");
      xact(1'b0, 'h82, 0, "sub_borrow"); xact(1'b0, 2, 0, "sub_borrow_flags");
      xact(1'b1, 0, 'hFF, "w_a"); xact(1'b1, 1, 'hFF, "w_b");
      xact(1'b0, 'h89, 0, "mul_ff"); xact(1'b0, 4, 0, "mul_rh"); xact(1'b0, 2, 0, "mul_flags");
      xact(1'b1, 3, 'h55, "w_ro"); xact(1'b0, 3, 0, "ro_kept");
      xact(1'b1, 'h20, 'h55, "w_unmapped"); xact(1'b0, 'h20, 0, "r_unmapped");

      // Reset in the middle of a multiply
      xact(1'b1, 0, 'h13, "w_a"); xact(1'b1, 1, 'h07, "w_b");
      i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = AW'('h89);
      @(posedge i_clk); #1;
      i_wb_stb = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_ack", 64'(o_wb_ack), 64'(0));
      check("mid_rst_stall", 64'(o_wb_stall), 64'(0));
      @(posedge i_clk); #1;
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(posedge i_clk); #1;
         check("mid_rst_noack", 64'(o_wb_ack), 64'(0));
      end
      for (int i = 0; i < 5; i++) xact(1'b0, i, 0, "mid_rst_reg");
      xact(1'b1, 0, 'h01, "w_a"); xact(1'b1, 1, 'h02, "w_b");
      xact(1'b0, 'h80, 0, "add_after_rst");

      // Back-to-back pipelined stream
      pw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      pa = '{0, 1, 'h85, 'h86, 'h84};
      pd = '{'h0F, 'hF0, 0, 0, 0};
      for (int i = 0; i < 5; i++) pe[i] = model_access(pw[i], pa[i], pd[i]);
      for (int i = 0; i < 5; i++) begin
         i_wb_stb = 1'b1; i_wb_we = pw[i]; i_wb_addr = AW'(pa[i]); i_wb_data = WIDTH'(pd[i]);
         @(posedge i_clk); #1;
         check("pipe_ack", 64'(o_wb_ack), 64'(1));
         check("pipe_data", 64'(o_wb_data), 64'(pe[i]));
      end
      i_wb_stb = 1'b0; i_wb_we = 1'b0;
      @(posedge i_clk); #1;
      check("idle_ack", 64'(o_wb_ack), 64'(0));
      check("idle_data", 64'(o_wb_data), 64'(0));
      xact(1'b0, 2, 0, "pipe_flags");

      // Randomized traffic
      for (int k = 0; k < 300; k++) begin
         sel = int'($urandom_range(0, 15));
         if (sel <= 2 && $urandom_range(0, 1) == 1) xact(1'b1, addrs[sel], rand_data(), "rnd_w");
         else if ($urandom_range(0, 9) == 0) xact(1'b1, addrs[sel], rand_data(), "rnd_wx");
         else xact(1'b0, addrs[sel], 0, "rnd_r");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
